// File: rtl/asc_arbiter.sv
// asc_arbiter: two-requester round-robin arbiter and sequencer for one shared
// add/subtract/compare unit.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   reqX_valid/ready/op/a/b/cin      request channels (X = 0, 1); ready is combinational
//   rsp_valid/ready/id/result/flag/cmp/err   registered tagged response channel
//   unit_a/b, unit_oprtn1..3, unit_cin/borin  registered drive to the shared unit
//   unit_sum/diff/cout/borout/aisbig/bisbig/equal  results returned by the unit
module asc_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [1:0]   req0_op,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic         req0_cin,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [1:0]   req1_op,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic         req1_cin,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_result,
    output logic         rsp_flag,
    output logic [2:0]   rsp_cmp,
    output logic         rsp_err,
    output logic [N-1:0] unit_a,
    output logic [N-1:0] unit_b,
    output logic         unit_oprtn1,
    output logic         unit_oprtn2,
    output logic         unit_oprtn3,
    output logic         unit_cin,
    output logic         unit_borin,
    input  logic [N-1:0] unit_sum,
    input  logic [N-1:0] unit_diff,
    input  logic         unit_cout,
    input  logic         unit_borout,
    input  logic         unit_aisbig,
    input  logic         unit_bisbig,
    input  logic         unit_equal
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_CMP = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    state_t       state;
    state_t       state_next;
    logic         ptr;
    logic [1:0]   op_q;
    logic         id_q;
    logic         grant0;
    logic         grant1;
    logic         accept;
    logic [1:0]   sel_op;
    logic [N-1:0] sel_a;
    logic [N-1:0] sel_b;
    logic         sel_cin;

    // Round-robin grant: a lone requester always wins, ptr breaks ties.
    assign grant0     = req0_valid && (!req1_valid || !ptr);
    assign grant1     = req1_valid && (!req0_valid || ptr);
    assign req0_ready = (state == IDLE) && !rst && grant0;
    assign req1_ready = (state == IDLE) && !rst && grant1;
    assign accept     = req0_ready || req1_ready;

    // Payload of the granted requester.
    assign sel_op  = req1_ready ? req1_op  : req0_op;
    assign sel_a   = req1_ready ? req1_a   : req0_a;
    assign sel_b   = req1_ready ? req1_b   : req0_b;
    assign sel_cin = req1_ready ? req1_cin : req0_cin;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: unit drive is loaded on accept so the selects are live
    // for exactly the EXEC cycle; responses are captured leaving EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr         <= 1'b0;
            op_q        <= 2'b00;
            id_q        <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_result  <= '0;
            rsp_flag    <= 1'b0;
            rsp_cmp     <= 3'b000;
            rsp_err     <= 1'b0;
            unit_a      <= '0;
            unit_b      <= '0;
            unit_oprtn1 <= 1'b0;
            unit_oprtn2 <= 1'b0;
            unit_oprtn3 <= 1'b0;
            unit_cin    <= 1'b0;
            unit_borin  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q        <= sel_op;
                        id_q        <= req1_ready;
                        unit_a      <= sel_a;
                        unit_b      <= sel_b;
                        unit_oprtn1 <= (sel_op == OP_ADD);
                        unit_oprtn2 <= (sel_op == OP_SUB);
                        unit_oprtn3 <= (sel_op == OP_CMP);
                        unit_cin    <= (sel_op == OP_ADD) && sel_cin;
                        unit_borin  <= (sel_op == OP_SUB) && sel_cin;
                    end
                end
                EXEC: begin
                    unit_oprtn1 <= 1'b0;
                    unit_oprtn2 <= 1'b0;
                    unit_oprtn3 <= 1'b0;
                    unit_cin    <= 1'b0;
                    unit_borin  <= 1'b0;
                    rsp_valid   <= 1'b1;
                    rsp_id      <= id_q;
                    rsp_err     <= (op_q == OP_ILL);
                    rsp_result  <= '0;
                    rsp_flag    <= 1'b0;
                    rsp_cmp     <= 3'b000;
                    case (op_q)
                        OP_ADD: begin
                            rsp_result <= unit_sum;
                            rsp_flag   <= unit_cout;
                        end
                        OP_SUB: begin
                            rsp_result <= unit_diff;
                            rsp_flag   <= unit_borout;
                        end
                        OP_CMP: rsp_cmp <= {unit_aisbig, unit_bisbig, unit_equal};
                        default: ;
                    endcase
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ptr       <= ~rsp_id;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
